// File: rtl/fpu_mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mul_arb_pkg
// Brief    : Shared constants and tag type for the FPU_MUL arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_mul_arb_pkg;

    localparam int C_NUM_REQ = 4;
    localparam int ID_W      = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } mul_tag_t;

endpackage
`default_nettype wire

// File: rtl/fpu_mul_rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mul_rr_grant
// Brief    : Combinational one-hot round-robin grant; FPU_MUL_ARB_PRIO_EN
//            gives requester 0 strict priority over the rotating group.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_mul_rr_grant
    import fpu_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_block,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id
);

    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_id;
    logic               w_found;
    int                 w_idx;

    always_comb begin
        w_cand  = i_req_valid;
        w_grant = '0;
        w_id    = '0;
        w_found = 1'b0;
        w_idx   = 0;
`ifdef FPU_MUL_ARB_PRIO_EN
        // Requester 0 bypasses the rotation; the others rotate among themselves.
        if (i_req_valid[0]) begin
            w_found    = 1'b1;
            w_grant[0] = 1'b1;
        end
        w_cand[0] = 1'b0;
`endif
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = (int'(i_ptr) + off) % NUM_REQ;
            if (!w_found && w_cand[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_id           = ID_W'(w_idx);
            end
        end
    end

    assign o_grant    = i_block ? '0 : w_grant;
    assign o_grant_id = w_id;

endmodule
`default_nettype wire

// File: rtl/fpu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mul_arbiter
// Brief    : Shares one fixed-latency FP32 multiplier among NUM_REQ requesters
//            with an id tag pipeline. Option macro: FPU_MUL_ARB_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_mul_arbiter
    import fpu_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clr,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    output logic                      o_mul_valid,
    output logic [DATA_W-1:0]         o_mul_a,
    output logic [DATA_W-1:0]         o_mul_b,
    input  logic [DATA_W-1:0]         i_mul_result,
    output logic                      o_rsp_valid,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_busy
);

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_hs;
    logic               w_ptr_move;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_tag_any;

    logic [ID_W-1:0]    r_ptr;
    logic               r_mul_valid;
    logic [DATA_W-1:0]  r_mul_a;
    logic [DATA_W-1:0]  r_mul_b;
    logic [ID_W-1:0]    r_issue_id;
    mul_tag_t           r_tag [MUL_LAT];
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;

    // Ready is suppressed during reset and flush so nothing is accepted and lost.
    fpu_mul_rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_grant (
        .i_req_valid (i_req_valid),
        .i_ptr       (r_ptr),
        .i_block     (i_clr | ~i_rst_n),
        .o_grant     (w_grant),
        .o_grant_id  (w_gnt_id)
    );

    assign o_req_ready = w_grant;
    assign w_hs        = |w_grant;
    assign w_ptr_nxt   = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

`ifdef FPU_MUL_ARB_PRIO_EN
    assign w_ptr_move = w_hs & ~w_grant[0];
`else
    assign w_ptr_move = w_hs;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_mul_valid <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_issue_id  <= '0;
            for (int i = 0; i < MUL_LAT; i++) r_tag[i] <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else if (i_clr) begin
            r_ptr       <= '0;
            r_mul_valid <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) r_tag[i] <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_mul_valid <= w_hs;
            if (w_hs) begin
                r_mul_a    <= i_req_a[w_gnt_id*DATA_W +: DATA_W];
                r_mul_b    <= i_req_b[w_gnt_id*DATA_W +: DATA_W];
                r_issue_id <= w_gnt_id;
            end
            if (w_ptr_move) r_ptr <= w_ptr_nxt;
            // Tag enters behind the issue stage so its last stage lines up with the product.
            r_tag[0] <= '{vld: r_mul_valid, id: r_issue_id};
            for (int i = 1; i < MUL_LAT; i++) r_tag[i] <= r_tag[i-1];
            r_rsp_valid <= r_tag[MUL_LAT-1].vld;
            if (r_tag[MUL_LAT-1].vld) begin
                r_rsp_id   <= r_tag[MUL_LAT-1].id;
                r_rsp_data <= i_mul_result;
            end
        end
    end

    always_comb begin
        w_tag_any = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) w_tag_any = w_tag_any | r_tag[i].vld;
    end

    assign o_mul_valid = r_mul_valid;
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = r_mul_valid | w_tag_any;

endmodule
`default_nettype wire

// File: tb/tb_fpu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_mul_arbiter
// Brief    : Directed self-checking bench for fpu_mul_arbiter (4 req, MUL_LAT 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_mul_arbiter;
    import fpu_mul_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      clr = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      mul_valid;
    logic [DATA_W-1:0]         mul_a;
    logic [DATA_W-1:0]         mul_b;
    logic [DATA_W-1:0]         mul_result = '0;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    // Per-requester operands and hand-computed FP32 products.
    logic [DATA_W-1:0] op_a [NUM_REQ] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F000000};
    logic [DATA_W-1:0] op_b [NUM_REQ] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [DATA_W-1:0] prod [NUM_REQ] = '{32'h3F800000, 32'h40800000, 32'h40C00000, 32'h40000000};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [ID_W+DATA_W-1:0] rq [$];
    int                     rcyc [$];

    fpu_mul_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .MUL_LAT (1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clr        (clr),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_mul_valid  (mul_valid),
        .o_mul_a      (mul_a),
        .o_mul_b      (mul_b),
        .i_mul_result (mul_result),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_data   (rsp_data),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_a[r*DATA_W +: DATA_W] = op_a[r];
            req_b[r*DATA_W +: DATA_W] = op_b[r];
        end
    end

    function automatic logic [DATA_W-1:0] fmul_lut(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        case ({a, b})
            {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h3F000000, 32'h40800000}: return 32'h40000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // One-cycle multiplier stand-in.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_valid) mul_result <= fmul_lut(mul_a, mul_b);
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            rq.push_back({rsp_id, rsp_data});
            rcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] v);
        req_valid = v;
        #1;
    endtask

    initial begin
        // Reset state, ready held low even with requests pending.
        drive(4'b1111);
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_mul_valid", 64'(mul_valid), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_rsp_data", 64'(rsp_data), 64'h0);
        req_valid = '0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // Single request from r2.
        drive(4'b0100);
        check("t1_ready", 64'(req_ready), 64'h4);
        step(1);
        req_valid = '0;
        check("t1_mul_valid", 64'(mul_valid), 64'h1);
        check("t1_mul_a", 64'(mul_a), 64'h40000000);
        check("t1_mul_b", 64'(mul_b), 64'h40400000);
        check("t1_busy", 64'(busy), 64'h1);
        step(1);
        check("t1_rsp_early", 64'(rsp_valid), 64'h0);
        step(1);
        check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t1_rsp_id", 64'(rsp_id), 64'h2);
        check("t1_rsp_data", 64'(rsp_data), 64'h40C00000);
        step(1);
        check("t1_rsp_pulse", 64'(rsp_valid), 64'h0);
        check("t1_busy_end", 64'(busy), 64'h0);

        // Flush to bring the pointer back to 0, then all four requesting.
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        rq.delete(); rcyc.delete();
        drive(4'b1111);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_ready%0d", i), 64'(req_ready), 64'(4'b0001 << (i % 4)));
            step(1);
        end
        req_valid = '0;
        step(4);
        check("t2_rsp_count", 64'(rq.size()), 64'd8);
        if (rq.size() == 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("t2_rsp%0d", i), 64'(rq[i]), 64'({2'(i % 4), prod[i % 4]}));
            check("t2_b2b", 64'(rcyc[7] - rcyc[0]), 64'd7);
        end

        // Pointer at 2 with r1 and r3 pending: wrap-around order.
        rq.delete(); rcyc.delete();
        drive(4'b0010);
        check("t3_prime", 64'(req_ready), 64'h2);
        step(1);
        drive(4'b1010);
        check("t3_g0", 64'(req_ready), 64'h8);
        step(1);
        check("t3_g1", 64'(req_ready), 64'h2);
        step(1);
        check("t3_g2", 64'(req_ready), 64'h8);
        step(1);
        req_valid = '0;
        step(4);
        check("t3_rsp_count", 64'(rq.size()), 64'd4);
        if (rq.size() == 4) begin
            check("t3_id0", 64'(rq[0][DATA_W +: ID_W]), 64'd1);
            check("t3_id1", 64'(rq[1][DATA_W +: ID_W]), 64'd3);
            check("t3_id2", 64'(rq[2][DATA_W +: ID_W]), 64'd1);
            check("t3_id3", 64'(rq[3][DATA_W +: ID_W]), 64'd3);
        end

        // Flush right after two handshakes drops both ops and resets the pointer.
        rq.delete(); rcyc.delete();
        drive(4'b0011);
        check("t4_g0", 64'(req_ready), 64'h1);
        step(1);
        check("t4_g1", 64'(req_ready), 64'h2);
        step(1);
        clr = 1'b1;
        drive(4'b1111);
        check("t4_clr_ready", 64'(req_ready), 64'h0);
        step(1);
        clr = 1'b0;
        drive(4'b0000);
        check("t4_busy", 64'(busy), 64'h0);
        check("t4_mul_valid", 64'(mul_valid), 64'h0);
        drive(4'b0110);
        check("t4_ptr", 64'(req_ready), 64'h2);
        req_valid = '0;
        step(4);
        check("t4_no_rsp", 64'(rq.size()), 64'd0);

        // Asynchronous reset in the middle of a burst.
        rq.delete(); rcyc.delete();
        drive(4'b1111);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_mul_valid", 64'(mul_valid), 64'h0);
        check("t5_busy", 64'(busy), 64'h0);
        check("t5_ready", 64'(req_ready), 64'h0);
        check("t5_mul_a", 64'(mul_a), 64'h0);
        check("t5_rsp_data", 64'(rsp_data), 64'h0);
        req_valid = '0;
        step(2);
        rst_n = 1'b1;
        step(5);
        check("t5_no_rsp", 64'(rq.size()), 64'd0);
        drive(4'b1010);
        check("t5_ptr", 64'(req_ready), 64'h2);
        req_valid = '0;
        step(1);

        // r0 and r2 competing.
        rq.delete(); rcyc.delete();
        drive(4'b0101);
`ifdef FPU_MUL_ARB_PRIO_EN
        check("t6_g0", 64'(req_ready), 64'h1);
        step(1);
        check("t6_g1", 64'(req_ready), 64'h1);
        step(1);
        check("t6_g2", 64'(req_ready), 64'h1);
        step(1);
`else
        check("t6_g0", 64'(req_ready), 64'h1);
        step(1);
        check("t6_g1", 64'(req_ready), 64'h4);
        step(1);
        check("t6_g2", 64'(req_ready), 64'h1);
        step(1);
`endif
        drive(4'b0100);
        check("t6_g3", 64'(req_ready), 64'h4);
        step(1);
        req_valid = '0;
        step(4);
        check("t6_rsp_count", 64'(rq.size()), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
